// File: rtl/mem_io_responder.sv
// mem_io_responder: byte-wide RAM plus an IO window (UART TX FIFO, RX read port, halt register).
// Define MEM_IO_OVF_CNT_EN to add a dropped-push counter readable at 0x30008 and on port ovf_cnt.
module mem_io_responder #(
    parameter int RAM_AW   = 17,
    parameter int TX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic        mem_rw,
    input  logic [31:0] mem_aout,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_pop,
    output logic        halt,
    output logic [7:0]  halt_code
`ifdef MEM_IO_OVF_CNT_EN
    ,
    output logic [7:0]  ovf_cnt
`endif
);
    localparam int PW    = $clog2(TX_DEPTH);
    localparam int CNT_W = PW + 1;

    localparam logic [3:0] REG_DATA = 4'h0;
    localparam logic [3:0] REG_CTRL = 4'h4;
    localparam logic [3:0] REG_OVF  = 4'h8;

    logic              is_io;
    logic [3:0]        reg_sel;
    logic [RAM_AW-1:0] ram_addr;
    logic              unused_bits;

    assign is_io    = (mem_aout[17:16] == 2'b11);
    assign reg_sel  = mem_aout[3:0];
    assign ram_addr = mem_aout[RAM_AW-1:0];

    // ---------------- RAM ----------------
    logic [7:0] ram [2**RAM_AW];

    // NOTE: RAM contents are deliberately not reset so the array maps onto block RAM;
    // only control state below sees rst_in.
    always_ff @(posedge clk) begin
        if (!rst_in && mem_rw && !is_io)
            ram[ram_addr] <= mem_dout;
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]       fifo [TX_DEPTH];
    logic [PW-1:0]    head, tail;
    logic [CNT_W-1:0] count;
    logic             push_req, push, pop, fifo_full, drop;

    assign tx_valid       = (count != '0);
    assign tx_data        = fifo[head];
    assign io_buffer_full = (count >= CNT_W'(TX_DEPTH - 1));
    assign fifo_full      = (count == CNT_W'(TX_DEPTH));
    assign pop            = tx_valid && tx_ready;
    assign push_req       = !rst_in && mem_rw && is_io && (reg_sel == REG_DATA);
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept the push.
    assign push           = push_req && (!fifo_full || pop);
    assign drop           = push_req && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (push)
            fifo[tail] <= mem_dout;
    end

    // NOTE: all clocked state uses non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------- Overflow counter ----------------
    logic [7:0] ovf_rd;
`ifdef MEM_IO_OVF_CNT_EN
    logic [7:0] ovf_q;

    always_ff @(posedge clk) begin
        if (rst_in)
            ovf_q <= 8'h00;
        else if (drop && ovf_q != 8'hFF)
            ovf_q <= ovf_q + 8'h01;
    end

    assign ovf_rd  = ovf_q;
    assign ovf_cnt = ovf_q;
`else
    assign ovf_rd = 8'h00;
`endif

    assign unused_bits = ^{mem_aout, drop};

    // ---------------- Halt register ----------------
    always_ff @(posedge clk) begin
        if (rst_in) begin
            halt      <= 1'b0;
            halt_code <= 8'h00;
        end else if (mem_rw && is_io && reg_sel == REG_CTRL) begin
            halt      <= 1'b1;
            halt_code <= mem_dout;
        end
    end

    // ---------------- Read path ----------------
    logic [7:0] io_rd;

    assign rx_pop = !rst_in && !mem_rw && is_io && (reg_sel == REG_DATA) && rx_valid;

    always_comb begin
        // NOTE: default first so every path assigns io_rd and no latch is inferred.
        io_rd = 8'h00;
        case (reg_sel)
            REG_DATA: io_rd = rx_valid ? rx_data : 8'h00;
            REG_CTRL: io_rd = {7'b0, io_buffer_full};
            REG_OVF:  io_rd = ovf_rd;
            default:  io_rd = 8'h00;
        endcase
    end

    // Idle cycles (addr 0, rw 0) are ordinary reads, so mem_din only holds across writes.
    always_ff @(posedge clk) begin
        if (rst_in)
            mem_din <= 8'h00;
        else if (!mem_rw)
            mem_din <= is_io ? io_rd : ram[ram_addr];
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: queue/associative-array model checked every cycle,
// plus directed literal checks for the listed scenarios.
module tb_mem_io_responder;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        mem_rw;
    logic [31:0] mem_aout;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_pop;
    logic        halt;
    logic [7:0]  halt_code;
`ifdef MEM_IO_OVF_CNT_EN
    logic [7:0]  ovf_cnt;
`endif

    always #5 clk = ~clk;

    mem_io_responder #(.RAM_AW(17), .TX_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_in         (rst_in),
        .mem_rw         (mem_rw),
        .mem_aout       (mem_aout),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_pop         (rx_pop),
        .halt           (halt),
        .halt_code      (halt_code)
`ifdef MEM_IO_OVF_CNT_EN
        ,
        .ovf_cnt        (ovf_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    bit armed = 1'b0;

    // Behavioural model state
    logic [7:0] m_ram [int];
    logic [7:0] m_q [$];
    logic [7:0] m_din;
    bit         m_din_known;
    logic       m_halt;
    logic [7:0] m_code;
    int         m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_pop();
        return !rst_in && !mem_rw && mem_aout[17:16] == 2'b11 && mem_aout[3:0] == 4'h0 && rx_valid;
    endfunction

    // Advance the model by one clock edge using the inputs presented this cycle.
    task automatic model_edge();
        bit         io;
        logic [3:0] sel;
        int         idx;
        bit         full_before;
        if (rst_in) begin
            m_din       = 8'h00;
            m_din_known = 1'b1;
            m_q.delete();
            m_halt      = 1'b0;
            m_code      = 8'h00;
            m_ovf       = 0;
            return;
        end
        io          = (mem_aout[17:16] == 2'b11);
        sel         = mem_aout[3:0];
        idx         = int'(mem_aout[16:0]);
        full_before = (m_q.size() >= DEPTH - 1);
        if (!mem_rw) begin
            if (!io) begin
                m_din_known = m_ram.exists(idx);
                if (m_din_known) m_din = m_ram[idx];
            end else begin
                m_din_known = 1'b1;
                case (sel)
                    4'h0:    m_din = rx_valid ? rx_data : 8'h00;
                    4'h4:    m_din = {7'b0, full_before};
`ifdef MEM_IO_OVF_CNT_EN
                    4'h8:    m_din = m_ovf[7:0];
`endif
                    default: m_din = 8'h00;
                endcase
            end
        end
        if (m_q.size() > 0 && tx_ready) void'(m_q.pop_front());
        if (mem_rw) begin
            if (!io) m_ram[idx] = mem_dout;
            else if (sel == 4'h0) begin
                if (m_q.size() < DEPTH) m_q.push_back(mem_dout);
                else if (m_ovf < 255) m_ovf++;
            end else if (sel == 4'h4) begin
                m_halt = 1'b1;
                m_code = mem_dout;
            end
        end
    endtask

    // Compare process: every negedge once the first reset edge has been seen.
    always @(negedge clk) begin
        if (armed) begin
            check("tx_valid", tx_valid, m_q.size() != 0);
            if (m_q.size() != 0) check("tx_data", tx_data, m_q[0]);
            check("io_buffer_full", io_buffer_full, m_q.size() >= DEPTH - 1);
            check("halt", halt, m_halt);
            check("halt_code", halt_code, m_code);
            if (m_din_known) check("mem_din", mem_din, m_din);
            check("rx_pop", rx_pop, exp_pop());
`ifdef MEM_IO_OVF_CNT_EN
            check("ovf_cnt", ovf_cnt, m_ovf);
`endif
        end
    end

    task automatic drive(input logic rw, input logic [31:0] a, input logic [7:0] d);
        mem_rw   = rw;
        mem_aout = a;
        mem_dout = d;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        armed = 1'b1;
    endtask

    task automatic op(input logic rw, input logic [31:0] a, input logic [7:0] d);
        drive(rw, a, d);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, 32'h0, 8'h00);
    endtask

    initial begin
        logic [7:0] pre [4];
        pre = '{8'h11, 8'h22, 8'h33, 8'h44};

        rst_in   = 1'b1;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        drive(1'b0, 32'h0, 8'h00);
        tick();
        tick();
        rst_in = 1'b0;
        check("reset mem_din", mem_din, 8'h00);
        check("reset tx_valid", tx_valid, 1'b0);
        check("reset full", io_buffer_full, 1'b0);
        check("reset halt", halt, 1'b0);

        op(1'b1, 32'h0, 8'h00);   // give address 0 a known value for idle reads

        // RAM write then read: data one cycle after the read address
        op(1'b1, 32'h10, 8'hA5);
        check("write holds mem_din", mem_din, 8'h00);
        op(1'b0, 32'h10, 8'h00);
        check("ram read 0x10", mem_din, 8'hA5);

        // Back-to-back pipelined reads
        for (int i = 0; i < 4; i++) op(1'b1, 32'h100 + i, pre[i]);
        for (int i = 0; i < 4; i++) begin
            op(1'b0, 32'h100 + i, 8'h00);
            check("burst read", mem_din, pre[i]);
        end

        // Fill TX FIFO with the sink stalled
        idle(1);
        for (int i = 0; i < 7; i++) begin
            op(1'b1, 32'h30000, 8'h50 + 8'(i));
            if (i == 5) check("full after 6", io_buffer_full, 1'b0);
        end
        check("full after 7", io_buffer_full, 1'b1);
        op(1'b0, 32'h30004, 8'h00);
        check("read full flag", mem_din, 8'h01);
        op(1'b1, 32'h30000, 8'h57);   // 8th accepted
        op(1'b1, 32'h30000, 8'h58);   // 9th dropped
`ifdef MEM_IO_OVF_CNT_EN
        check("ovf_cnt after drop", ovf_cnt, 8'h01);
        op(1'b0, 32'h30008, 8'h00);
        check("read ovf reg", mem_din, 8'h01);
`else
        op(1'b0, 32'h30008, 8'h00);
        check("read ovf reg absent", mem_din, 8'h00);
`endif
        op(1'b0, 32'h3000C, 8'h00);
        check("read unmapped io", mem_din, 8'h00);
        check("head byte", tx_data, 8'h50);

        // Push and pop together while full, then drain
        tx_ready = 1'b1;
        op(1'b1, 32'h30000, 8'h60);
        check("full push+pop head", tx_data, 8'h51);
        check("full push+pop full", io_buffer_full, 1'b1);
        idle(1);
        check("drain head", tx_data, 8'h52);
        idle(9);
        check("drained", tx_valid, 1'b0);

        // RX read port
        tx_ready = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h41;
        drive(1'b0, 32'h30000, 8'h00);
        #1 check("rx_pop asserted", rx_pop, 1'b1);
        tick();
        check("rx byte", mem_din, 8'h41);
        drive(1'b0, 32'h0, 8'h00);
        #1 check("rx_pop one cycle", rx_pop, 1'b0);
        tick();
        rx_valid = 1'b0;
        drive(1'b0, 32'h30000, 8'h00);
        #1 check("no pop when empty", rx_pop, 1'b0);
        tick();
        check("rx empty reads 0", mem_din, 8'h00);

        // Halt register, then reset with queued bytes and a RAM write in the reset cycle
        op(1'b1, 32'h30004, 8'h2A);
        check("halt set", halt, 1'b1);
        check("halt_code", halt_code, 8'h2A);
        op(1'b1, 32'h30004, 8'h33);
        check("halt_code update", halt_code, 8'h33);
        op(1'b1, 32'h30000, 8'h70);
        op(1'b1, 32'h30000, 8'h71);
        rst_in = 1'b1;
        op(1'b1, 32'h10, 8'hEE);
        rst_in = 1'b0;
        check("post-reset halt", halt, 1'b0);
        check("post-reset tx_valid", tx_valid, 1'b0);
        check("post-reset mem_din", mem_din, 8'h00);
        op(1'b0, 32'h10, 8'h00);
        check("reset-cycle write suppressed", mem_din, 8'hA5);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
